mod_adder_pipe: RTL and testbench
=================================

MOD_ADDER_PIPE -- requirements
Module: mod_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal values are 32 (SHA-256) and 64 (SHA-512).
REQ-002 SHALL have parameter NUM_OPS, default 5, number of operands summed per beat; legal range is 2..8.
REQ-003 SHALL define the derived constant CW = max(1, ceil(log2(NUM_OPS))) as the carry-count width.
REQ-004 SHALL have the port: clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have the port: rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have the port: in_valid, input, 1, operand beat present.
REQ-007 SHALL have the port: in_ready, output, 1, beat accepted when in_valid && in_ready at a clk edge.
REQ-008 SHALL have the port: ops, input, NUM_OPS*WIDTH, packed operands; operand i is in bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have the port: acc_en, input, 1, add the accumulator to this beat's sum and store the result back.
REQ-010 SHALL have the port: acc_clr, input, 1, zero the accumulator before this beat is applied.
REQ-011 SHALL have the port: out_valid, output, 1, result present.
REQ-012 SHALL have the port: out_ready, input, 1, result consumed when out_valid && out_ready.
REQ-013 SHALL have the port: sum, output, WIDTH, result modulo 2^WIDTH.
REQ-014 SHALL have the port: carry, output, CW, count of discarded wraps (the true sum shifted right by WIDTH, truncated to CW bits).

Function
REQ-015 SHALL be built as a two-stage pipeline.
  - Stage 1 registers two partial sums: operands 0..ceil(NUM_OPS/2)-1 and the remaining operands. Each partial sum is WIDTH+CW bits wide, so it is lossless.
  - Stage 1 also registers acc_en and acc_clr for the beat.
  - Stage 2 registers sum and carry.
REQ-016 SHALL use a single global advance enable, en = out_ready || !out_valid.
  - in_ready = en.
  - Both stages load only when en = 1; otherwise all pipeline registers hold.
REQ-017 SHALL have a latency of exactly 2 clk edges from acceptance to out_valid when unstalled, and SHALL sustain one beat per cycle.
REQ-018 SHALL track validity per stage: v1 <= in_valid when en = 1; out_valid <= v1 when en = 1.
REQ-019 SHALL hold sum and carry stable while out_valid && !out_ready.
REQ-020 SHALL compute stage 2 as total = p0 + p1 + A, where:
  - A = 0 if acc_clr = 1 or acc_en = 0;
  - A = acc (the accumulator register) otherwise.
REQ-021 SHALL drive sum = total[WIDTH-1:0] and carry = total[WIDTH +: CW].
REQ-022 SHALL update the accumulator when stage 2 loads a valid beat:
  - acc <= sum if acc_en = 1;
  - acc <= 0 if acc_clr = 1 and acc_en = 0;
  - otherwise acc is unchanged.
REQ-023 SHALL give back-to-back acc_en beats serialized semantics: beat k+1 sees the acc value written by beat k, with no bubble.
REQ-024 SHALL NOT update the accumulator during a stall or on an invalid stage-1 slot.
REQ-025 SHALL ignore ops, acc_en and acc_clr when in_valid = 0.
REQ-026 SHALL ignore the contents of the ops bus for beats with in_valid && !in_ready.
REQ-027 SHALL have no internal storage beyond the two stages; upstream holds the beat until accepted.

Reset
REQ-028 SHALL, on rst = 1 asynchronously, force v1 = 0, out_valid = 0, sum = 0, carry = 0 and acc = 0; in_ready then reads 1.
REQ-029 SHALL discard any in-flight beats when reset is asserted mid-operation; no partial result is presented after reset.
REQ-030 SHALL accept a beat at the first clk edge after rst deasserts if in_valid = 1.

Verification
REQ-031 SHALL be verified with WIDTH=32, NUM_OPS=2:
  - ops {0x4ABFFFFF, 0x10101010} -> sum = 0x5AD0100F, carry = 0, out_valid rises 2 edges after acceptance;
  - ops {5, 10} -> sum = 15.
REQ-032 SHALL be verified with WIDTH=32, NUM_OPS=5: all operands 0xFFFFFFFF -> sum = 0xFFFFFFFB, carry = 4.
REQ-033 SHALL be verified with WIDTH=64, NUM_OPS=5:
  - four consecutive beats with acc_en = 1 (first beat also acc_clr = 1), each beat ops = {1, 0, 0, 0, 0};
  - required: sums 1, 2, 3, 4 on consecutive cycles, with no bubbles.
REQ-034 SHALL be verified with a backpressure test: hold out_ready = 0 for 3 cycles while sending 3 beats.
  - Required: in_ready drops once both stages are full.
  - Required: the output is held unchanged.
  - Required: after release, all 3 results appear in order with none lost or duplicated.
REQ-035 SHALL be verified with a mid-stream reset: assert rst with 2 beats in flight.
  - Required: out_valid = 0, sum = 0 and acc = 0 immediately (asynchronously).
  - Required: the first post-reset beat {7, 8} yields sum = 15, with acc not carrying over.
REQ-036 SHALL be verified with random stimulus against a reference model of the modular sum plus carry, with random in_valid/out_ready toggling, for at least 10000 beats at both WIDTH values.

Source files
------------

// File: rtl/mod_adder_pipe.sv
// Two-stage multi-operand modular adder for SHA-2 message/round sums, with an
// optional running accumulator and a single global stall enable.
module mod_adder_pipe #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 5,
    localparam int CW     = ($clog2(NUM_OPS) > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] ops,
    input  logic                     acc_en,
    input  logic                     acc_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         sum,
    output logic [CW-1:0]            carry
);

    localparam int H  = (NUM_OPS + 1) / 2;
    localparam int PW = WIDTH + CW;

    // Lossless sum of operands lo..hi-1; CW guard bits hold every wrap.
    function automatic logic [PW-1:0] part_sum(input logic [NUM_OPS*WIDTH-1:0] v,
                                               input int lo, input int hi);
        logic [PW-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (i >= lo && i < hi) begin
                s = s + {{CW{1'b0}}, v[i*WIDTH +: WIDTH]};
            end
        end
        return s;
    endfunction

    logic            en;
    logic            vld_p1;
    logic            acc_en_p1;
    logic            acc_clr_p1;
    logic [PW-1:0]   psum_lo_p1;
    logic [PW-1:0]   psum_hi_p1;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_term;
    logic [PW-1:0]   total;

    assign en       = out_ready || !out_valid;
    assign in_ready = en;

    // ---- stage 1: partial sums and per-beat accumulator controls ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            acc_en_p1  <= 1'b0;
            acc_clr_p1 <= 1'b0;
        end else if (en) begin
            vld_p1     <= in_valid;
            acc_en_p1  <= in_valid && acc_en;
            acc_clr_p1 <= in_valid && acc_clr;
        end
    end

    always_ff @(posedge clk) begin
        if (en && in_valid) begin
            psum_lo_p1 <= part_sum(ops, 0, H);
            psum_hi_p1 <= part_sum(ops, H, NUM_OPS);
        end
    end

    // Accumulator is read here and written in the same stage, so consecutive
    // acc_en beats chain without a bubble. Overflow past PW bits is the
    // intended truncation of the carry count.
    always_comb begin
        acc_term = (acc_en_p1 && !acc_clr_p1) ? acc : '0;
        total    = psum_lo_p1 + psum_hi_p1 + {{CW{1'b0}}, acc_term};
    end

    // ---- stage 2: result, carry count and accumulator update ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= '0;
            acc       <= '0;
        end else if (en) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                sum   <= total[WIDTH-1:0];
                carry <= total[WIDTH +: CW];
                if (acc_en_p1) begin
                    acc <= total[WIDTH-1:0];
                end else if (acc_clr_p1) begin
                    acc <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_adder_pipe.sv
// Drives three adder configurations from one shared stream and checks each
// against its own reference-model scoreboard, plus directed latency/stall/reset steps.
module tb_mod_adder_pipe;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         acc_en;
    logic         acc_clr;
    logic         out_ready;
    logic [319:0] opsw;

    logic [63:0]  ops_a;
    logic [159:0] ops_b;
    logic         rdy_a, rdy_b, rdy_c;
    logic         ov_a, ov_b, ov_c;
    logic [31:0]  sum_a, sum_b;
    logic [63:0]  sum_c;
    logic [0:0]   car_a;
    logic [2:0]   car_b, car_c;

    int nvec = 0;
    int nerr = 0;
    int nacc = 0;

    logic [127:0] qa[$];
    logic [127:0] qb[$];
    logic [127:0] qc[$];
    logic [63:0]  macc_a, macc_b, macc_c;

    assign ops_a = {opsw[64 +: 32], opsw[0 +: 32]};
    for (genvar g = 0; g < 5; g++) begin : g_b
        assign ops_b[g*32 +: 32] = opsw[g*64 +: 32];
    end

    mod_adder_pipe #(.WIDTH(32), .NUM_OPS(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .ops(ops_a),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_a), .out_ready(out_ready),
        .sum(sum_a), .carry(car_a));

    mod_adder_pipe #(.WIDTH(32), .NUM_OPS(5)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .ops(ops_b),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_b), .out_ready(out_ready),
        .sum(sum_b), .carry(car_b));

    mod_adder_pipe #(.WIDTH(64), .NUM_OPS(5)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .ops(opsw),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_c), .out_ready(out_ready),
        .sum(sum_c), .carry(car_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: true sum of the first n operands plus the optional accumulator.
    function automatic logic [127:0] model(input int w, input int n, input int cw,
                                           input logic [319:0] o, input logic e,
                                           input logic c, input logic [63:0] a);
        logic [127:0] t, mask, s, cy;
        mask = (w == 64) ? {64'b0, {64{1'b1}}} : {96'b0, {32{1'b1}}};
        t = (c || !e) ? 128'd0 : {64'b0, a};
        for (int i = 0; i < n; i++) t = t + ({64'b0, o[i*64 +: 64]} & mask);
        s  = t & mask;
        cy = (t >> w) & ((128'd1 << cw) - 128'd1);
        return {cy[63:0], s[63:0]};
    endfunction

    function automatic logic [319:0] mk(input logic [63:0] o0, input logic [63:0] o1,
                                        input logic [63:0] o2, input logic [63:0] o3,
                                        input logic [63:0] o4);
        return {o4, o3, o2, o1, o0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on acceptance, pop and compare on consumption.
    always @(negedge clk) begin
        logic [127:0] e;
        logic [127:0] got;
        if (!rst) begin
            if (in_valid && rdy_a) begin
                e = model(32, 2, 1, opsw, acc_en, acc_clr, macc_a);
                qa.push_back(e);
                if (acc_en) macc_a = e[63:0]; else if (acc_clr) macc_a = '0;
            end
            if (in_valid && rdy_b) begin
                e = model(32, 5, 3, opsw, acc_en, acc_clr, macc_b);
                qb.push_back(e);
                if (acc_en) macc_b = e[63:0]; else if (acc_clr) macc_b = '0;
            end
            if (in_valid && rdy_c) begin
                e = model(64, 5, 3, opsw, acc_en, acc_clr, macc_c);
                qc.push_back(e);
                nacc++;
                if (acc_en) macc_c = e[63:0]; else if (acc_clr) macc_c = '0;
            end
            if (ov_a && out_ready) begin
                got = {64'(car_a), 64'(sum_a)};
                e = (qa.size() > 0) ? qa.pop_front() : {128{1'bx}};
                nvec++;
                assert (got === e) else begin
                    nerr++;
                    $error("FAIL sb_a got %h exp %h", got, e);
                end
            end
            if (ov_b && out_ready) begin
                got = {64'(car_b), 64'(sum_b)};
                e = (qb.size() > 0) ? qb.pop_front() : {128{1'bx}};
                nvec++;
                assert (got === e) else begin
                    nerr++;
                    $error("FAIL sb_b got %h exp %h", got, e);
                end
            end
            if (ov_c && out_ready) begin
                got = {64'(car_c), sum_c};
                e = (qc.size() > 0) ? qc.pop_front() : {128{1'bx}};
                nvec++;
                assert (got === e) else begin
                    nerr++;
                    $error("FAIL sb_c got %h exp %h", got, e);
                end
            end
        end
    end

    task automatic junk();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) opsw[i*32 +: 32] = $urandom;
        acc_en  = 1'($urandom);
        acc_clr = 1'($urandom);
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send(input logic [319:0] o, input logic e, input logic c);
        int t;
        t = 0;
        in_valid = 1'b1;
        opsw     = o;
        acc_en   = e;
        acc_clr  = c;
        while (!rdy_c && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("send_timeout", 64'(rdy_c), 64'd1);
        @(posedge clk); #1;
        junk();
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((qa.size() + qb.size() + qc.size()) != 0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk(tag, 64'(qa.size() + qb.size() + qc.size()), 64'd0);
    endtask

    initial begin
        int cyc;
        int start;
        rst = 1'b1; in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
        out_ready = 1'b1; opsw = '0;
        macc_a = '0; macc_b = '0; macc_c = '0;

        #2;
        chk("rst_out_valid", 64'(ov_c), 64'd0);
        chk("rst_sum", sum_c, 64'd0);
        chk("rst_carry", 64'(car_b), 64'd0);
        chk("rst_in_ready", 64'(rdy_c), 64'd1);
        chk("rst_acc", u_c.acc, 64'd0);

        @(posedge clk); #1;
        rst = 1'b0;

        // latency of two edges, first edge after reset accepts
        send(mk(64'h4ABFFFFF, 64'h10101010, 0, 0, 0), 1'b0, 1'b0);
        chk("lat_edge1", 64'(ov_a), 64'd0);
        @(posedge clk); #1;
        chk("lat_edge2", 64'(ov_a), 64'd1);
        chk("n2_sum", 64'(sum_a), 64'h5AD0100F);
        chk("n2_carry", 64'(car_a), 64'd0);

        send(mk(5, 10, 0, 0, 0), 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("n2_small", 64'(sum_a), 64'd15);

        send(mk(64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF), 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("n5_sum", 64'(sum_b), 64'hFFFFFFFB);
        chk("n5_carry", 64'(car_b), 64'd4);

        // back-to-back accumulation, one result per cycle
        send(mk(1, 0, 0, 0, 0), 1'b1, 1'b1);
        send(mk(1, 0, 0, 0, 0), 1'b1, 1'b0);
        chk("acc_1", {63'd0, ov_c} + sum_c, 64'd2);
        send(mk(1, 0, 0, 0, 0), 1'b1, 1'b0);
        chk("acc_2", {63'd0, ov_c} + sum_c, 64'd3);
        send(mk(1, 0, 0, 0, 0), 1'b1, 1'b0);
        chk("acc_3", {63'd0, ov_c} + sum_c, 64'd4);
        @(posedge clk); #1;
        chk("acc_4", {63'd0, ov_c} + sum_c, 64'd5);
        drain("drain_acc");

        // backpressure: both stages fill, output held, nothing lost
        out_ready = 1'b0;
        send(mk(100, 23, 0, 0, 0), 1'b0, 1'b0);
        send(mk(200, 22, 0, 0, 0), 1'b0, 1'b0);
        in_valid = 1'b1; opsw = mk(300, 21, 0, 0, 0); acc_en = 1'b0; acc_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 64'(rdy_c), 64'd0);
            chk("bp_hold_sum", sum_c, 64'd123);
            chk("bp_hold_valid", 64'(ov_c), 64'd1);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        send(mk(300, 21, 0, 0, 0), 1'b0, 1'b0);
        drain("drain_bp");

        // asynchronous reset with two beats in flight
        send(mk(11, 0, 0, 0, 0), 1'b1, 1'b1);
        send(mk(22, 0, 0, 0, 0), 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_valid", 64'(ov_c), 64'd0);
        chk("mrst_sum", sum_c, 64'd0);
        chk("mrst_acc", u_c.acc, 64'd0);
        qa.delete(); qb.delete(); qc.delete();
        macc_a = '0; macc_b = '0; macc_c = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        send(mk(7, 8, 0, 0, 0), 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("post_rst_valid", 64'(ov_a), 64'd1);
        chk("post_rst_sum_a", 64'(sum_a), 64'd15);
        chk("post_rst_sum_c", sum_c, 64'd15);
        drain("drain_rst");

        // random traffic with random handshakes
        start = nacc;
        cyc = 0;
        while (nacc < start + 10000 && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            acc_en    = ($urandom_range(0, 9) < 3);
            acc_clr   = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 5; i++) begin
                case ($urandom_range(0, 7))
                    0:       opsw[i*64 +: 64] = '1;
                    1:       opsw[i*64 +: 64] = '0;
                    default: opsw[i*64 +: 64] = {$urandom, $urandom};
                endcase
            end
        end
        chk("rand_beats", 64'(nacc - start >= 10000), 64'd1);
        drain("drain_rand");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
